// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

  typedef enum logic [1:0] {
    F_DIV  = 2'b00,
    F_DIVU = 2'b01,
    F_REM  = 2'b10,
    F_REMU = 2'b11
  } div_func3_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } div_ctrl_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request / response / divider bundle of the divider issue controller.
//
// Handshake semantics (request and response sides alike):
//   a transfer happens on a rising clk edge where valid & ready are both 1.
//   valid may not depend on ready; once raised, valid and its payload stay
//   stable until the transfer. ready may depend on valid.
//   The divider side is a pulse protocol: div_go is high for one cycle,
//   div_done is high for one cycle with div_rd valid in that cycle.
interface div_issue_ctrl_if #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 5
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*2-1:0]     req_func3;
  logic [N_REQ*32-1:0]    req_rs1;
  logic [N_REQ*32-1:0]    req_rs2;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic                   flush;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [TAG_W-1:0]       resp_tag;
  logic [31:0]            resp_data;
  logic                   resp_fast;
  logic                   resp_err;
  logic                   err;
  logic                   div_go;
  logic [1:0]             div_func3;
  logic [31:0]            div_rs1;
  logic [31:0]            div_rs2;
  logic                   div_done;
  logic [31:0]            div_rd;

  // Environment side: requesters, response consumer and the divider.
  modport master (
    output req_valid, req_func3, req_rs1, req_rs2, req_tag, flush,
    output resp_ready, div_done, div_rd,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_data,
    input  resp_fast, resp_err, err, div_go, div_func3, div_rs1, div_rs2
  );

  // Controller side.
  modport slave (
    input  req_valid, req_func3, req_rs1, req_rs2, req_tag, flush,
    input  resp_ready, div_done, div_rd,
    output req_ready, resp_valid, resp_id, resp_tag, resp_data,
    output resp_fast, resp_err, err, div_go, div_func3, div_rs1, div_rs2
  );

endinterface

// File: rtl/div_rr_arb.sv
// Round-robin arbiter: lowest valid index at or after ptr wins.
module div_rr_arb #(
  parameter int N_REQ = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  // Scan from ptr upwards with wrap; first valid requester is granted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any && valid[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
          any       = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller in front of the divider: arbitrates requesters, answers
// divide-by-zero / signed overflow directly, sequences go/done, handles
// flush and a done watchdog.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            clr,
  div_issue_ctrl_if.slave bus,
  output div_ctrl_state_e dbg_state
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  div_ctrl_state_e  state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [1:0]       func3_q, func3_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [31:0]      data_q, data_d;
  logic             fast_q, fast_d;
  logic             rerr_q, rerr_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             accept;

  logic [1:0]       sel_func3;
  logic [31:0]      sel_rs1;
  logic [31:0]      sel_rs2;
  logic [TAG_W-1:0] sel_tag;
  logic             is_signed, is_rem, div0, ovf, is_fast;
  logic [31:0]      fast_data;

  div_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .valid     (bus.req_valid),
    .ptr       (rr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Grants are only offered when idle and not being flushed.
  assign accept        = (state_q == S_IDLE) && !bus.flush && grant_any;
  assign bus.req_ready = accept ? grant : '0;

  // Pick the operands of the granted requester.
  always_comb begin
    sel_func3 = '0;
    sel_rs1   = '0;
    sel_rs2   = '0;
    sel_tag   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_func3 = bus.req_func3[i*2 +: 2];
        sel_rs1   = bus.req_rs1[i*32 +: 32];
        sel_rs2   = bus.req_rs2[i*32 +: 32];
        sel_tag   = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // RISC-V M corner cases resolved without the divider.
  always_comb begin
    is_signed = (sel_func3 == F_DIV) || (sel_func3 == F_REM);
    is_rem    = (sel_func3 == F_REM) || (sel_func3 == F_REMU);
    div0      = (sel_rs2 == '0);
    ovf       = is_signed && (sel_rs1 == INT_MIN) && (sel_rs2 == '1);
    is_fast   = div0 || ovf;
    if (div0) fast_data = is_rem ? sel_rs1 : DIV0_QUOT;
    else      fast_data = is_rem ? '0 : INT_MIN;
  end

  // Next-state and datapath updates of the issue FSM.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    func3_d = func3_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    tag_d   = tag_q;
    id_d    = id_q;
    data_d  = data_q;
    fast_d  = fast_q;
    rerr_d  = rerr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          func3_d = sel_func3;
          rs1_d   = sel_rs1;
          rs2_d   = sel_rs2;
          tag_d   = sel_tag;
          id_d    = grant_idx;
          rr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          if (is_fast) begin
            state_d = S_RESP;
            data_d  = fast_data;
            fast_d  = 1'b1;
            rerr_d  = 1'b0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = bus.flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.flush) begin
          // A done in the flush cycle already retired the op: nothing to drain.
          wd_d    = '0;
          state_d = bus.div_done ? S_IDLE : S_DRAIN;
        end else if (bus.div_done) begin
          state_d = S_RESP;
          data_d  = bus.div_rd;
          fast_d  = 1'b0;
          rerr_d  = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d = S_RESP;
          data_d  = '0;
          fast_d  = 1'b0;
          rerr_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.div_done) begin
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.flush || bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      func3_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      fast_q  <= 1'b0;
      rerr_q  <= 1'b0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      func3_q <= func3_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
      id_q    <= id_d;
      data_q  <= data_d;
      fast_q  <= fast_d;
      rerr_q  <= rerr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_tag   = tag_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_fast  = fast_q;
  assign bus.resp_err   = rerr_q;
  assign bus.err        = err_q;
  assign bus.div_go     = (state_q == S_ISSUE);
  assign bus.div_func3  = func3_q;
  assign bus.div_rs1    = rs1_q;
  assign bus.div_rs2    = rs2_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: vector table, flush/arbitration/watchdog
// sequences and randomized ops against an arithmetic reference model.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int N_REQ   = 2;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 16;
  localparam int ID_W    = 1;
  localparam int SB_W    = 2 + ID_W + TAG_W + 32;

  logic            clk;
  logic            clr;
  div_ctrl_state_e dbg_state;

  div_issue_ctrl_if #(.N_REQ(N_REQ), .TAG_W(TAG_W)) bus ();

  div_issue_ctrl #(.N_REQ(N_REQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: sim time exceeded, required completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int go_cnt = 0;
  logic [SB_W-1:0] exp_q[$];

  always @(posedge clk) if (bus.div_go) go_cnt <= go_cnt + 1;

  // ---------------- divider model ----------------
  bit          div_auto = 1'b1;
  int          div_lat_max = 3;
  logic        auto_done, man_done;
  logic [31:0] auto_rd, man_rd;

  assign bus.div_done = div_auto ? auto_done : man_done;
  assign bus.div_rd   = div_auto ? auto_rd   : man_rd;

  // Reference arithmetic: {fast, result} from the RISC-V M rules.
  function automatic logic [32:0] ref_div(input logic [1:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic sgn, rem;
    int   sa, sb;
    sgn = (f3 == 2'b00) || (f3 == 2'b10);
    rem = (f3 == 2'b10) || (f3 == 2'b11);
    sa  = $signed(a);
    sb  = $signed(b);
    if (b == 32'd0) return {1'b1, rem ? a : 32'hFFFF_FFFF};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {1'b1, rem ? 32'h0 : 32'h8000_0000};
    case (f3)
      2'b00:   return {1'b0, 32'(sa / sb)};
      2'b01:   return {1'b0, a / b};
      2'b10:   return {1'b0, 32'(sa % sb)};
      default: return {1'b0, a % b};
    endcase
  endfunction

  initial begin
    logic [32:0] r;
    int          lat;
    auto_done = 1'b0;
    auto_rd   = '0;
    forever begin
      @(negedge clk);
      auto_done = 1'b0;
      auto_rd   = '0;
      if (div_auto && !clr && bus.div_go) begin
        r   = ref_div(bus.div_func3, bus.div_rs1, bus.div_rs2);
        lat = $urandom_range(div_lat_max, 1);
        repeat (lat) @(negedge clk);
        auto_done = 1'b1;
        auto_rd   = r[31:0];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SB_W-1:0] pack(input logic e, input logic f, input logic [ID_W-1:0] id,
                                           input logic [TAG_W-1:0] tag, input logic [31:0] d);
    return {e, f, id, tag, d};
  endfunction

  function automatic logic [SB_W-1:0] dut_word();
    return pack(bus.resp_err, bus.resp_fast, bus.resp_id, bus.resp_tag, bus.resp_data);
  endfunction

  task automatic set_req(input int rid, input logic [1:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.req_valid[rid]            = 1'b1;
    bus.req_func3[rid*2 +: 2]     = f3;
    bus.req_rs1[rid*32 +: 32]     = a;
    bus.req_rs2[rid*32 +: 32]     = b;
    bus.req_tag[rid*TAG_W +: TAG_W] = tag;
  endtask

  // Returns at the falling edge following the accepting rising edge.
  task automatic wait_accept(input int rid, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      if (bus.req_ready[rid]) ok = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input int rid, input logic [1:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag,
                       input logic [31:0] exp_data, input bit exp_fast, input int ready_delay);
    bit              ok, got;
    int              go0;
    logic [SB_W-1:0] e;
    go0 = go_cnt;
    set_req(rid, f3, a, b, tag);
    wait_accept(rid, ok);
    bus.req_valid = '0;
    check("accept", ok, 1'b1);
    if (!ok) return;
    exp_q.push_back(pack(1'b0, exp_fast, ID_W'(rid), tag, exp_data));
    if (exp_fast) check("fast_latency", bus.resp_valid, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (bus.resp_valid) got = 1'b1;
      else @(negedge clk);
    end
    check("resp_seen", got, 1'b1);
    if (!got) begin
      void'(exp_q.pop_front());
      return;
    end
    repeat (ready_delay) begin
      check("resp_hold", {bus.resp_valid, dut_word()}, {1'b1, exp_q[0]});
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check("resp_word", dut_word(), e);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("resp_drop", bus.resp_valid, 1'b0);
    check("go_count", go_cnt - go0, exp_fast ? 0 : 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               rid;
    logic [1:0]       f3;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_data;
    bit               exp_fast;
  } vec_t;

  vec_t vecs[9];

  // ---------------- main sequence ----------------
  initial begin
    bit          ok;
    int          cyc, go0, grants, resps;
    int          order[4];
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic [1:0]  rf;
    logic [SB_W-1:0] e;

    vecs[0] = '{0, F_DIVU, 32'd100,        32'd10,        5'h01, 32'd10,        1'b0};
    vecs[1] = '{0, F_DIV,  32'hFFFF_FFEB,  32'd3,         5'h02, 32'hFFFF_FFF9, 1'b0};
    vecs[2] = '{1, F_DIV,  32'd5,          32'd0,         5'h03, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{1, F_REMU, 32'd7,          32'd0,         5'h04, 32'd7,         1'b1};
    vecs[4] = '{0, F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'h05, 32'h8000_0000, 1'b1};
    vecs[5] = '{0, F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'h06, 32'h0,         1'b1};
    vecs[6] = '{1, F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'h07, 32'h0,         1'b0};
    vecs[7] = '{1, F_REMU, 32'd100,        32'd7,         5'h08, 32'd2,         1'b0};
    vecs[8] = '{0, F_DIV,  32'd7,          32'hFFFF_FFFE, 5'h1F, 32'hFFFF_FFFD, 1'b0};

    bus.req_valid  = '0;
    bus.req_func3  = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_tag    = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    man_done       = 1'b0;
    man_rd         = '0;
    clr            = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ctrl", {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_tag, bus.resp_fast,
                       bus.resp_err, bus.err, bus.div_go, bus.div_func3}, '0);
    check("rst_data", {bus.resp_data, bus.div_rs1, bus.div_rs2}, '0);
    check("rst_state", dbg_state, S_IDLE);
    clr = 1'b0;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 9; i++)
      do_op(vecs[i].rid, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag,
            vecs[i].exp_data, vecs[i].exp_fast, i % 3);

    // Flush while idle blocks grants but has no other effect
    set_req(0, F_DIVU, 32'd30, 32'd6, 5'h0B);
    bus.flush = 1'b1;
    repeat (2) begin
      #1 check("flush_idle_ready", bus.req_ready, '0);
      @(negedge clk);
    end
    bus.flush = 1'b0;
    bus.req_valid = '0;
    do_op(0, F_DIVU, 32'd30, 32'd6, 5'h0B, 32'd5, 1'b0, 0);

    // Flush in RESP beats resp_ready and drops the response
    set_req(0, F_DIV, 32'd5, 32'd0, 5'h0C);
    wait_accept(0, ok);
    bus.req_valid = '0;
    check("flush_resp_accept", ok, 1'b1);
    check("flush_resp_valid", bus.resp_valid, 1'b1);
    bus.flush = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.resp_ready = 1'b0;
    check("flush_resp_drop", bus.resp_valid, 1'b0);

    // Flush in WAIT: drain until done, no response, then REM -33/8
    div_auto = 1'b0;
    go0 = go_cnt;
    set_req(0, F_DIVU, 32'd100, 32'd7, 5'h0D);
    wait_accept(0, ok);
    bus.req_valid = '0;
    check("flush_wait_go", bus.div_go, 1'b1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    set_req(1, F_REM, 32'hFFFF_FFDF, 32'd8, 5'h0E);
    repeat (6) begin
      #1;
      check("drain_ready", bus.req_ready, '0);
      check("drain_resp", bus.resp_valid, 1'b0);
      @(negedge clk);
    end
    bus.req_valid = '0;
    man_done = 1'b1;
    man_rd   = 32'h1234_5678;
    @(negedge clk);
    man_done = 1'b0;
    check("drain_no_resp", bus.resp_valid, 1'b0);
    check("drain_idle", dbg_state, S_IDLE);
    check("drain_go_count", go_cnt - go0, 1);
    div_auto = 1'b1;
    do_op(1, F_REM, 32'hFFFF_FFDF, 32'd8, 5'h0E, 32'hFFFF_FFFF, 1'b0, 1);

    // Round robin with both requesters continuously valid
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    set_req(0, F_DIVU, 32'd50, 32'd5, 5'h0A);
    set_req(1, F_DIV, 32'hFFFF_FFF8, 32'd2, 5'h15);
    bus.resp_ready = 1'b1;
    grants = 0;
    resps  = 0;
    for (int c = 0; c < 300 && !(grants == 4 && resps == 4); c++) begin
      if (grants >= 4) bus.req_valid = '0;
      #1;
      if (bus.req_ready != '0) begin
        check("rr_onehot", $onehot(bus.req_ready), 1'b1);
        order[grants] = bus.req_ready[1] ? 1 : 0;
        if (bus.req_ready[1]) exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 5'h15, 32'hFFFF_FFFC));
        else                  exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 5'h0A, 32'd10));
        grants++;
      end
      if (bus.resp_valid) begin
        e = exp_q.pop_front();
        check("rr_resp", dut_word(), e);
        resps++;
      end
      @(negedge clk);
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    check("rr_grants", grants, 4);
    check("rr_resps", resps, 4);
    for (int i = 0; i < 4; i++) check("rr_order", order[i], i % 2);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rf = 2'($urandom_range(3, 0));
      case ($urandom_range(5, 0))
        0:       begin ra = $urandom; rb = 32'd0; end
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       begin ra = 32'($urandom_range(200, 0)); rb = 32'($urandom_range(12, 1)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      r = ref_div(rf, ra, rb);
      div_lat_max = $urandom_range(6, 1);
      do_op($urandom_range(1, 0), rf, ra, rb, 5'($urandom), r[31:0], r[32], $urandom_range(3, 0));
    end
    check("no_err_yet", bus.err, 1'b0);

    // Watchdog: done never arrives
    div_auto = 1'b0;
    man_done = 1'b0;
    set_req(0, F_DIVU, 32'd9, 32'd3, 5'h06);
    wait_accept(0, ok);
    bus.req_valid = '0;
    cyc = 0;
    while (!bus.resp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("wd_cycles", cyc, TIMEOUT + 1);
    check("wd_word", dut_word(), pack(1'b1, 1'b0, 1'b0, 5'h06, 32'd0));
    check("wd_err", bus.err, 1'b1);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("wd_drop", bus.resp_valid, 1'b0);
    check("err_sticky", bus.err, 1'b1);

    // clr in the middle of WAIT
    set_req(1, F_DIV, 32'd20, 32'd4, 5'h07);
    wait_accept(1, ok);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    check("pre_clr_state", dbg_state, S_WAIT);
    #2 clr = 1'b1;
    #1;
    check("clr_ctrl", {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_tag, bus.resp_fast,
                       bus.resp_err, bus.err, bus.div_go, bus.div_func3}, '0);
    check("clr_data", {bus.resp_data, bus.div_rs1, bus.div_rs2}, '0);
    check("clr_state", dbg_state, S_IDLE);
    @(negedge clk);
    clr = 1'b0;
    div_auto = 1'b1;
    do_op(0, F_REMU, 32'd17, 32'd5, 5'h11, 32'd2, 1'b0, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
